acc_mop_stream: RTL and testbench

- Streaming, sequential multi-operand adder/subtracter.
- Operands arrive one per handshake on a valid/ready input channel. The block accumulates them modulo 2^width and emits one sum per operand group on a valid/ready output channel.
- It is the serial counterpart of the packed-vector multi-operand adder. Datapath blocks use it when operands are produced one at a time instead of side by side.
- The accumulate adder is the library carry-propagate adder, instantiated with the same speed parameter.

---
 rtl/acc_mop_stream.sv | 171 +++++++++++++++++
 tb/tb_acc_mop_stream.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_mop_stream.sv
// ---------------------------------------------------------------------------
// lau_pkg     : shared arithmetic-library types (adder speed selection).
// lau_cpa     : library carry-propagate adder, s_o = a_i + b_i + c_i mod 2^width.
// acc_mop_stream : streaming multi-operand adder/subtracter.
//
// acc_mop_stream ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   op_valid_i   operand valid
//   op_ready_o   operand ready (high while accumulating)
//   op_i         operand, width bits
//   op_sub_i     1: subtract op_i, 0: add op_i
//   op_last_i    operand closes the group
//   sum_valid_o  group result valid
//   sum_ready_i  group result ready
//   sum_o        group result, modulo 2^width
//   count_o      number of operands in the group
//   forced_o     group was closed by the depth limit rather than op_last_i
//
// Operands are accumulated one per handshake. A group closes on op_last_i or
// on the depth-th operand; the result is then presented on the output channel
// and no operand is accepted until it has been taken.
// ---------------------------------------------------------------------------

package lau_pkg;
  typedef enum logic {SLOW = 1'b0, FAST = 1'b1} speed_e;
endpackage

module lau_cpa #(
  parameter int               width = 8,
  parameter lau_pkg::speed_e  speed = lau_pkg::FAST
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  input  logic             c_i,
  output logic [width-1:0] s_o
);

  if (speed == lau_pkg::FAST) begin : g_fast
    // Leave carry structure to the synthesis tool's adder mapping.
    assign s_o = a_i + b_i + {{(width-1){1'b0}}, c_i};
  end else begin : g_slow
    // Explicit ripple chain: smallest structure, longest carry path.
    always_comb begin
      logic             c;
      logic [width-1:0] s;
      c = c_i;
      s = '0;
      for (int i = 0; i < width; i++) begin
        s[i] = a_i[i] ^ b_i[i] ^ c;
        c    = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
      end
      s_o = s;
    end
  end

endmodule

module acc_mop_stream #(
  parameter int               width = 8,
  parameter int               depth = 4,
  parameter lau_pkg::speed_e  speed = lau_pkg::FAST
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       op_valid_i,
  output logic                       op_ready_o,
  input  logic [width-1:0]           op_i,
  input  logic                       op_sub_i,
  input  logic                       op_last_i,
  output logic                       sum_valid_o,
  input  logic                       sum_ready_i,
  output logic [width-1:0]           sum_o,
  output logic [$clog2(depth+1)-1:0] count_o,
  output logic                       forced_o
);

  localparam int CW = $clog2(depth + 1);

  typedef enum logic {ACC = 1'b0, OUT = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic signed [width-1:0] acc_q, acc_d;
  logic        [CW-1:0]    cnt_q, cnt_d;
  logic signed [width-1:0] sum_q, sum_d;
  logic        [CW-1:0]    count_q, count_d;
  logic                    forced_q, forced_d;

  logic                    op_hs;
  logic        [width-1:0] addend;
  logic        [width-1:0] acc_sum;
  logic        [CW-1:0]    cnt_inc;
  logic                    at_depth;

  assign op_ready_o  = (state_q == ACC);
  assign sum_valid_o = (state_q == OUT);
  assign op_hs       = op_valid_i & op_ready_o;

  // Subtraction as acc + ~op + 1: invert the operand and use the carry-in.
  assign addend = op_sub_i ? ~op_i : op_i;

  lau_cpa #(
    .width (width),
    .speed (speed)
  ) u_cpa (
    .a_i (acc_q),
    .b_i (addend),
    .c_i (op_sub_i),
    .s_o (acc_sum)
  );

  assign cnt_inc  = cnt_q + CW'(1);
  assign at_depth = (cnt_inc == CW'(depth));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    count_d  = count_q;
    forced_d = forced_q;
    unique case (state_q)
      ACC: begin
        if (op_hs) begin
          if (op_last_i || at_depth) begin
            // Close the group: capture the result and start the next group
            // from zero on the same edge.
            sum_d    = acc_sum;
            count_d  = cnt_inc;
            forced_d = at_depth & ~op_last_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = OUT;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_inc;
          end
        end
      end
      OUT: begin
        if (sum_ready_i) begin
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ACC;
      acc_q    <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      count_q  <= '0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      count_q  <= count_d;
      forced_q <= forced_d;
    end
  end

  assign sum_o    = sum_q;
  assign count_o  = count_q;
  assign forced_o = forced_q;

endmodule

// File: tb/tb_acc_mop_stream.sv
// ---------------------------------------------------------------------------
// Testbench for acc_mop_stream (width=8, depth=4).
// The stimulus process pushes expected group results into a queue as soon as
// the reference model sees a group close; a monitor pops and compares every
// result the DUT hands over on the output channel.
// ---------------------------------------------------------------------------
module tb_acc_mop_stream;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  typedef struct {
    int sum;
    int cnt;
    int forced;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          op_valid_i = 1'b0;
  logic          op_ready_o;
  logic [W-1:0]  op_i = '0;
  logic          op_sub_i = 1'b0;
  logic          op_last_i = 1'b0;
  logic          sum_valid_o;
  logic          sum_ready_i = 1'b1;
  logic [W-1:0]  sum_o;
  logic [CW-1:0] count_o;
  logic          forced_o;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  int   grp[$];
  bit   rand_ready = 1'b0;

  acc_mop_stream #(.width(W), .depth(D)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .op_valid_i  (op_valid_i),
    .op_ready_o  (op_ready_o),
    .op_i        (op_i),
    .op_sub_i    (op_sub_i),
    .op_last_i   (op_last_i),
    .sum_valid_o (sum_valid_o),
    .sum_ready_i (sum_ready_i),
    .sum_o       (sum_o),
    .count_o     (count_o),
    .forced_o    (forced_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: a group is a list of signed contributions; its result is
  // their plain integer sum reduced modulo 2^W.
  task automatic model_accept(input int op, input bit sub, input bit last);
    exp_t e;
    int   total;
    grp.push_back(sub ? -op : op);
    if (last || grp.size() == D) begin
      total = 0;
      foreach (grp[k]) total += grp[k];
      e.sum    = total & ((1 << W) - 1);
      e.cnt    = grp.size();
      e.forced = (grp.size() == D && !last) ? 1 : 0;
      exp_q.push_back(e);
      grp.delete();
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    grp.delete();
    exp_q.delete();
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the
  // edge on which the operand was accepted.
  task automatic send(input int op, input bit sub, input bit last);
    bit done = 1'b0;
    op_valid_i = 1'b1;
    op_i       = W'(op);
    op_sub_i   = sub;
    op_last_i  = last;
    for (int t = 0; t < 200 && !done; t++) begin
      if (op_ready_o) begin
        @(posedge clk); #1;
        model_accept(op, sub, last);
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: operand %0d not accepted within 200 cycles", op);
    end
    op_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every output handshake is compared against the queue head.
  always @(negedge clk) begin
    if (!rst_i && sum_valid_o && sum_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: sum %0d count %0d, none expected", sum_o, count_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum_o", int'(sum_o), e.sum);
        check("count_o", int'(count_o), e.cnt);
        check("forced_o", int'(forced_o), e.forced);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) sum_ready_i = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_sum_valid", int'(sum_valid_o), 0);
    check("rst_op_ready", int'(op_ready_o), 1);
    check("rst_sum", int'(sum_o), 0);
    check("rst_count", int'(count_o), 0);
    check("rst_forced", int'(forced_o), 0);

    // 1: 3+5+7, single-cycle result
    send(3, 0, 0);
    send(5, 0, 0);
    send(7, 0, 1);
    check("t1_valid_out", int'(sum_valid_o), 1);
    check("t1_ready_out", int'(op_ready_o), 0);
    idle(1);
    check("t1_valid_after", int'(sum_valid_o), 0);
    check("t1_ready_after", int'(op_ready_o), 1);

    // 2: mixed add/sub, then wraparound
    send(10, 0, 0);
    send(3, 1, 0);
    send(20, 1, 1);
    send(200, 0, 0);
    send(100, 0, 1);

    // 3: forced close on depth, then a one-operand group
    send(1, 0, 0);
    send(2, 0, 0);
    send(3, 0, 0);
    send(4, 0, 0);
    send(9, 0, 1);
    // op_last on the depth-th operand is not forced
    send(1, 1, 0);
    send(1, 1, 0);
    send(1, 1, 0);
    send(1, 1, 1);

    // 4: backpressure holds the result; held operand waits for the handshake
    idle(1);
    sum_ready_i = 1'b0;
    send(1, 0, 0);
    send(2, 0, 1);
    op_valid_i = 1'b1;
    op_i       = W'(9);
    op_sub_i   = 1'b0;
    op_last_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_valid_hold", int'(sum_valid_o), 1);
      check("t4_sum_hold", int'(sum_o), 3);
      check("t4_count_hold", int'(count_o), 2);
      check("t4_ready_low", int'(op_ready_o), 0);
      idle(1);
    end
    sum_ready_i = 1'b1;
    send(9, 0, 1);
    idle(1);

    // 5: bubbles inside a group
    send(1, 0, 0);
    idle(3);
    send(2, 0, 1);
    idle(1);

    // 6a: reset mid-group discards the partial group
    send(1, 0, 0);
    send(2, 0, 0);
    do_reset();
    check("t6a_valid", int'(sum_valid_o), 0);
    check("t6a_ready", int'(op_ready_o), 1);
    send(6, 0, 1);
    idle(1);

    // 6b: reset while a result is held discards it
    sum_ready_i = 1'b0;
    send(4, 0, 1);
    idle(1);
    do_reset();
    check("t6b_valid", int'(sum_valid_o), 0);
    check("t6b_ready", int'(op_ready_o), 1);
    sum_ready_i = 1'b1;
    send(6, 0, 1);
    idle(1);

    // Random traffic with random output backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(int'($urandom_range(0, (1 << W) - 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0));
      idle(int'($urandom_range(0, 2)));
    end
    rand_ready  = 1'b0;
    sum_ready_i = 1'b1;
    // Close any partial group so every queued result drains.
    send(0, 0, 1);
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) idle(1);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d results still outstanding", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
